// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ack memory
// handshake, a counted M-extension stall and a sticky halt on SYSTEM or illegal opcodes.
//
// state  | meaning
// FETCH  | request instruction word, load IR on ack
// DECODE | classify opcode, latch datapath controls
// EXEC   | ALU cycle
// MEM    | data access for Load/Store, held until ack
// WB     | register writeback and PC update
// MULDIV | M-extension stall, MULDIV_CYCLES long
// HALT   | absorbing until reset
module mc_control_fsm #(
   parameter int MULDIV_CYCLES = 4,
   parameter int HAS_MULDIV    = 1,
   parameter int ALUOP_W       = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4:0]         opcode,
   input  logic               funct7_0,
   input  logic               mem_ack,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_we,
   output logic               pc_we,
   output logic               branch,
   output logic               memRead,
   output logic               memWrite,
   output logic               memtoReg,
   output logic               ALUSrc,
   output logic               RegWrite,
   output logic               pc_gen_sel,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         rd_sel,
   output logic               muldiv_busy,
   output logic               halted,
   output logic               illegal,
   output logic [2:0]         state
);

   localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_MULDIV = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_ARITHI = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_ARITHR = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               load_q, store_q;

   logic [ALUOP_W-1:0] d_aluop;
   logic               d_alusrc, d_memtoreg, d_pc_gen_sel, d_branch;
   logic [1:0]         d_rd_sel;
   logic               d_load, d_store, d_system, d_legal, d_muldiv;

   always_comb begin
      d_aluop      = '0;
      d_alusrc     = 1'b0;
      d_memtoreg   = 1'b0;
      d_rd_sel     = 2'b00;
      d_pc_gen_sel = 1'b0;
      d_branch     = 1'b0;
      d_load       = 1'b0;
      d_store      = 1'b0;
      d_system     = 1'b0;
      d_legal      = 1'b1;
      case (opcode)
         OP_ARITHR: d_aluop = ALUOP_W'(2'b10);
         OP_LOAD: begin
            d_alusrc   = 1'b1;
            d_memtoreg = 1'b1;
            d_load     = 1'b1;
         end
         OP_STORE: begin
            d_alusrc = 1'b1;
            d_store  = 1'b1;
         end
         OP_BRANCH: begin
            d_aluop  = ALUOP_W'(2'b01);
            d_branch = 1'b1;
         end
         OP_ARITHI: begin
            d_aluop  = ALUOP_W'(2'b11);
            d_alusrc = 1'b1;
         end
         OP_JALR: begin
            d_rd_sel     = 2'b10;
            d_pc_gen_sel = 1'b1;
         end
         OP_JAL:    d_rd_sel = 2'b10;
         OP_AUIPC:  d_rd_sel = 2'b01;
         OP_LUI:    d_rd_sel = 2'b11;
         OP_SYSTEM: d_system = 1'b1;
         default:   d_legal  = 1'b0;
      endcase
      d_muldiv = (opcode == OP_ARITHR) && funct7_0 && (HAS_MULDIV != 0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Decode outputs hold from one DECODE cycle to the next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         ALUOp      <= '0;
         ALUSrc     <= 1'b0;
         memtoReg   <= 1'b0;
         rd_sel     <= 2'b00;
         pc_gen_sel <= 1'b0;
         branch     <= 1'b0;
         load_q     <= 1'b0;
         store_q    <= 1'b0;
         illegal    <= 1'b0;
      end else if (state_q == S_DECODE) begin
         ALUOp      <= d_aluop;
         ALUSrc     <= d_alusrc;
         memtoReg   <= d_memtoreg;
         rd_sel     <= d_rd_sel;
         pc_gen_sel <= d_pc_gen_sel;
         branch     <= d_branch;
         load_q     <= d_load;
         store_q    <= d_store;
         if (!d_legal) illegal <= 1'b1;
         if (d_muldiv) cnt_q   <= CNT_W'(MULDIV_CYCLES - 1);
      end else if (state_q == S_MULDIV && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ack) state_d = S_DECODE;
         S_DECODE: begin
            if (!d_legal || d_system) state_d = S_HALT;
            else if (d_muldiv)        state_d = S_MULDIV;
            else                      state_d = S_EXEC;
         end
         S_EXEC:   state_d = (load_q || store_q) ? S_MEM : S_WB;
         S_MEM:    if (mem_ack) state_d = load_q ? S_WB : S_FETCH;
         S_MULDIV: if (cnt_q == '0) state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // Strobes are forced low while reset is held so a dropped request stays dropped.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      RegWrite    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      muldiv_busy = 1'b0;
      halted      = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ack;
            end
            S_MEM: begin
               mem_req  = 1'b1;
               memRead  = load_q;
               memWrite = store_q;
               mem_we   = store_q;
               pc_we    = store_q && mem_ack;
            end
            S_MULDIV: muldiv_busy = 1'b1;
            S_WB: begin
               RegWrite = !(branch || store_q);
               pc_we    = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: default instance plus HAS_MULDIV=0 and MULDIV_CYCLES=1 variants.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] opcode = 5'b0;
   logic       funct7_0 = 1'b0;
   logic       mem_ack = 1'b0;

   logic       mem_req, mem_we, ir_we, pc_we, branch, memRead, memWrite, memtoReg;
   logic       ALUSrc, RegWrite, pc_gen_sel, muldiv_busy, halted, illegal;
   logic [1:0] ALUOp, rd_sel;
   logic [2:0] state;

   logic       b_mem_req, b_mem_we, b_ir_we, b_pc_we, b_branch, b_memRead, b_memWrite, b_memtoReg;
   logic       b_ALUSrc, b_RegWrite, b_pc_gen_sel, b_muldiv_busy, b_halted, b_illegal;
   logic [1:0] b_ALUOp, b_rd_sel;
   logic [2:0] b_state;

   logic       c_mem_req, c_mem_we, c_ir_we, c_pc_we, c_branch, c_memRead, c_memWrite, c_memtoReg;
   logic       c_ALUSrc, c_RegWrite, c_pc_gen_sel, c_muldiv_busy, c_halted, c_illegal;
   logic [1:0] c_ALUOp, c_rd_sel;
   logic [2:0] c_state;

   int checks = 0;
   int failures = 0;

   // {mem_req, mem_we, memRead, memWrite, RegWrite, ir_we, pc_we}
   wire [6:0] sb = {mem_req, mem_we, memRead, memWrite, RegWrite, ir_we, pc_we};

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_0(funct7_0), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .branch(branch),
      .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg), .ALUSrc(ALUSrc),
      .RegWrite(RegWrite), .pc_gen_sel(pc_gen_sel), .ALUOp(ALUOp), .rd_sel(rd_sel),
      .muldiv_busy(muldiv_busy), .halted(halted), .illegal(illegal), .state(state)
   );

   mc_control_fsm #(.MULDIV_CYCLES(4), .HAS_MULDIV(0), .ALUOP_W(2)) dut_nomd (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_0(funct7_0), .mem_ack(mem_ack),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .ir_we(b_ir_we), .pc_we(b_pc_we), .branch(b_branch),
      .memRead(b_memRead), .memWrite(b_memWrite), .memtoReg(b_memtoReg), .ALUSrc(b_ALUSrc),
      .RegWrite(b_RegWrite), .pc_gen_sel(b_pc_gen_sel), .ALUOp(b_ALUOp), .rd_sel(b_rd_sel),
      .muldiv_busy(b_muldiv_busy), .halted(b_halted), .illegal(b_illegal), .state(b_state)
   );

   mc_control_fsm #(.MULDIV_CYCLES(1), .HAS_MULDIV(1), .ALUOP_W(2)) dut_md1 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_0(funct7_0), .mem_ack(mem_ack),
      .mem_req(c_mem_req), .mem_we(c_mem_we), .ir_we(c_ir_we), .pc_we(c_pc_we), .branch(c_branch),
      .memRead(c_memRead), .memWrite(c_memWrite), .memtoReg(c_memtoReg), .ALUSrc(c_ALUSrc),
      .RegWrite(c_RegWrite), .pc_gen_sel(c_pc_gen_sel), .ALUOp(c_ALUOp), .rd_sel(c_rd_sel),
      .muldiv_busy(c_muldiv_busy), .halted(c_halted), .illegal(c_illegal), .state(c_state)
   );

   task automatic do_reset();
      rst_n   = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      opcode  = 5'b01100;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || sb !== 7'b0) begin
         failures++;
         $display("FAIL reset_state: state=%0d strobes=%b, expected 0 / 0000000", state, sb);
      end
      checks++;
      if ({ALUOp, ALUSrc, memtoReg, rd_sel, pc_gen_sel, branch} !== 8'b0) begin
         failures++;
         $display("FAIL reset_decode: got %b, expected 00000000",
                  {ALUOp, ALUSrc, memtoReg, rd_sel, pc_gen_sel, branch});
      end
      checks++;
      if ({muldiv_busy, halted, illegal} !== 3'b0 || b_state !== 3'd0 || c_state !== 3'd0) begin
         failures++;
         $display("FAIL reset_flags: busy/halt/ill=%b b_state=%0d c_state=%0d, expected 000/0/0",
                  {muldiv_busy, halted, illegal}, b_state, c_state);
      end
      @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || ir_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_stale_ack: state=%0d ir_we=%b, expected 0/0", state, ir_we);
      end
   endtask

   task automatic test_r_type();
      logic [2:0] es  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
      logic [6:0] esb [5] = '{7'b1000010, 7'b0, 7'b0, 7'b0000101, 7'b1000010};
      int pcw = 0;
      do_reset();
      opcode = 5'b01100; funct7_0 = 1'b0; mem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (state !== es[i] || sb !== esb[i]) begin
            failures++;
            $display("FAIL r_type c%0d: state=%0d strobes=%b, expected %0d/%b", i, state, sb, es[i], esb[i]);
         end
         if (i == 3) begin
            checks++;
            if (ALUOp !== 2'b10 || ALUSrc !== 1'b0 || rd_sel !== 2'b00) begin
               failures++;
               $display("FAIL r_type_decode: ALUOp=%b ALUSrc=%b rd_sel=%b, expected 10/0/00", ALUOp, ALUSrc, rd_sel);
            end
         end
         if (i < 4 && pc_we === 1'b1) pcw++;
         @(posedge clk); #1;
      end
      checks++;
      if (pcw != 1) begin
         failures++;
         $display("FAIL r_type_pc_we: pulses=%0d, expected 1", pcw);
      end
   endtask

   task automatic test_load_wait();
      logic [2:0] es  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
      logic [6:0] esb [9] = '{7'b1000010, 7'b0, 7'b0, 7'b1010000, 7'b1010000, 7'b1010000,
                              7'b1010000, 7'b0000101, 7'b1000000};
      logic       ack [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      opcode = 5'b00000; funct7_0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         mem_ack = ack[i];
         #1;
         checks++;
         if (state !== es[i] || sb !== esb[i]) begin
            failures++;
            $display("FAIL load_wait c%0d: state=%0d strobes=%b, expected %0d/%b", i, state, sb, es[i], esb[i]);
         end
         if (i == 7) begin
            checks++;
            if (memtoReg !== 1'b1 || ALUSrc !== 1'b1) begin
               failures++;
               $display("FAIL load_wb_decode: memtoReg=%b ALUSrc=%b, expected 1/1", memtoReg, ALUSrc);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_muldiv();
      logic [2:0] es  [8] = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd0};
      logic [2:0] ebs [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4};
      logic [2:0] ecs [8] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd0, 3'd1, 3'd5, 3'd4};
      int busy = 0;
      do_reset();
      opcode = 5'b01100; funct7_0 = 1'b1; mem_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (state !== es[i] || b_state !== ebs[i] || c_state !== ecs[i]) begin
            failures++;
            $display("FAIL muldiv c%0d: states a/b/c=%0d/%0d/%0d, expected %0d/%0d/%0d",
                     i, state, b_state, c_state, es[i], ebs[i], ecs[i]);
         end
         if (muldiv_busy === 1'b1) busy++;
         if (i == 6) begin
            checks++;
            if (RegWrite !== 1'b1 || pc_we !== 1'b1 || ALUOp !== 2'b10) begin
               failures++;
               $display("FAIL muldiv_wb: RegWrite=%b pc_we=%b ALUOp=%b, expected 1/1/10", RegWrite, pc_we, ALUOp);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (busy != 4) begin
         failures++;
         $display("FAIL muldiv_busy_len: cycles=%0d, expected 4", busy);
      end
      funct7_0 = 1'b0;
   endtask

   task automatic test_halt();
      logic [4:0] ops [2] = '{5'b11100, 5'b11111};
      logic       eil [2] = '{1'b0, 1'b1};
      for (int t = 0; t < 2; t++) begin
         do_reset();
         opcode = ops[t]; funct7_0 = 1'b0; mem_ack = 1'b1;
         @(posedge clk); @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== 3'd6 || halted !== 1'b1 || illegal !== eil[t] || sb !== 7'b0) begin
               failures++;
               $display("FAIL halt op%b c%0d: state=%0d halted=%b illegal=%b strobes=%b, expected 6/1/%b/0000000",
                        ops[t], i, state, halted, illegal, sb, eil[t]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] op  [9] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000,
                              5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
      logic [2:0] es  [9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      logic [6:0] esb [9] = '{7'b1000010, 7'b0, 7'b0, 7'b0000001, 7'b1000010,
                              7'b0, 7'b0, 7'b1101001, 7'b1000000};
      logic       ack [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      int pcw = 0;
      do_reset();
      funct7_0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         opcode  = op[i];
         mem_ack = ack[i];
         #1;
         checks++;
         if (state !== es[i] || sb !== esb[i]) begin
            failures++;
            $display("FAIL branch_store c%0d: state=%0d strobes=%b, expected %0d/%b", i, state, sb, es[i], esb[i]);
         end
         if (i == 2 || i == 3) begin
            checks++;
            if (branch !== 1'b1 || ALUOp !== 2'b01) begin
               failures++;
               $display("FAIL branch_decode c%0d: branch=%b ALUOp=%b, expected 1/01", i, branch, ALUOp);
            end
         end
         if (i == 7) begin
            checks++;
            if (branch !== 1'b0 || ALUSrc !== 1'b1) begin
               failures++;
               $display("FAIL store_decode: branch=%b ALUSrc=%b, expected 0/1", branch, ALUSrc);
            end
         end
         if (i < 8 && pc_we === 1'b1) pcw++;
         @(posedge clk); #1;
      end
      checks++;
      if (pcw != 2) begin
         failures++;
         $display("FAIL branch_store_pc_we: pulses=%0d, expected 2", pcw);
      end
   endtask

   task automatic test_reset_midflight();
      // MUL, reset in second MULDIV cycle
      do_reset();
      opcode = 5'b01100; funct7_0 = 1'b1; mem_ack = 1'b1;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      checks++;
      if (state !== 3'd5 || muldiv_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_muldiv_pre: state=%0d busy=%b, expected 5/1", state, muldiv_busy);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd0 || sb !== 7'b0 || muldiv_busy !== 1'b0 || ALUOp !== 2'b00) begin
         failures++;
         $display("FAIL mid_muldiv_reset: state=%0d strobes=%b busy=%b ALUOp=%b, expected 0/0000000/0/00",
                  state, sb, muldiv_busy, ALUOp);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd0 || sb !== 7'b0) begin
         failures++;
         $display("FAIL stale_ack_in_reset: state=%0d strobes=%b, expected 0/0000000", state, sb);
      end
      rst_n = 1'b1; mem_ack = 1'b0; funct7_0 = 1'b0;
      #1;
      checks++;
      if (sb !== 7'b1000000) begin
         failures++;
         $display("FAIL refetch_req: strobes=%b, expected 1000000", sb);
      end
      @(posedge clk); #1;
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || ir_we !== 1'b1) begin
         failures++;
         $display("FAIL refetch_ack: state=%0d ir_we=%b, expected 0/1", state, ir_we);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd1) begin
         failures++;
         $display("FAIL refetch_decode: state=%0d, expected 1", state);
      end

      // Store, reset during stalled MEM
      do_reset();
      opcode = 5'b01000; mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      checks++;
      if (state !== 3'd3 || sb !== 7'b1101000) begin
         failures++;
         $display("FAIL mid_mem_pre: state=%0d strobes=%b, expected 3/1101000", state, sb);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || sb !== 7'b0) begin
         failures++;
         $display("FAIL mid_mem_reset: state=%0d strobes=%b, expected 0/0000000", state, sb);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd0 || pc_we !== 1'b0) begin
         failures++;
         $display("FAIL mid_mem_stale_ack: state=%0d pc_we=%b, expected 0/0", state, pc_we);
      end
      rst_n = 1'b1; mem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load_wait();
      test_muldiv();
      test_halt();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the RV32 datapath. It generalises the single-cycle opcode decoder into a state machine that fetches an instruction, decodes `opcode` into datapath controls, and sequences EXEC/MEM/WB with a req/ack memory handshake. It also adds a parametrised multi-cycle M-extension stall and a sticky halt on SYSTEM or illegal opcodes. It sits between the instruction register and the datapath muxes, register file, PC and the unified memory port.

## Interface
- `MULDIV_CYCLES`, default 4: EXEC cycles for MUL/DIV; legal range 1–32.
- `HAS_MULDIV`, default 1: 0 means R-type with `funct7_0=1` is handled as a plain R-type.
- `ALUOP_W`, default 2: width of `ALUOp`.
- Reset: one clock; reset is synchronous and active-low.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `opcode`, in, 5: `inst[6:2]` from the IR; valid from DECODE onward.
- `funct7_0`, in, 1: `inst[25]` (M-extension select).
- `mem_ack`, in, 1: memory completes the current request this cycle.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: write qualifier for `mem_req`.
- `ir_we`, out, 1: load the IR.
- `pc_we`, out, 1: update the PC.
- `branch`, `memRead`, `memWrite`, `memtoReg`, `ALUSrc`, `RegWrite`, `pc_gen_sel`, out, 1 each: datapath controls.
- `ALUOp`, out, `ALUOP_W`: ALU operation class.
- `rd_sel`, out, 2: writeback source select.
- `muldiv_busy`, out, 1: high while in MULDIV.
- `halted`, out, 1: high in HALT.
- `illegal`, out, 1: sticky flag for an undefined opcode.
- `state`, out, 3: debug view of the current state.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULDIV=5, HALT=6. Encoding 7 goes to FETCH.
- Opcode encodings: Load 00000, Arith_I 00100, AUIPC 00101, Store 01000, Arith_R 01100, LUI 01101, Branch 11000, JALR 11001, JAL 11011, SYSTEM 11100. Any other value is illegal.
- Registered decode outputs (`ALUOp`, `ALUSrc`, `memtoReg`, `rd_sel`, `pc_gen_sel`, `branch`) are loaded on the DECODE cycle. They hold until the next DECODE.
- Decode values, listed as ALUOp / ALUSrc / memtoReg / rd_sel / pc_gen_sel / branch:
  - R: 10/0/0/00/0/0
  - Load: 00/1/1/00/0/0
  - Store: 00/1/0/00/0/0
  - Branch: 01/0/0/00/0/1
  - Arith_I: 11/1/0/00/0/0
  - JALR: 00/0/0/10/1/0
  - JAL: 00/0/0/10/0/0
  - AUIPC: 00/0/0/01/0/0
  - LUI: 00/0/0/11/0/0
- FETCH:
  - `mem_req=1`, `mem_we=0`.
  - On `mem_ack`: pulse `ir_we` and go to DECODE. Otherwise stay.
- DECODE:
  - SYSTEM → HALT.
  - Illegal opcode → HALT and set `illegal`.
  - R-type with `funct7_0 & HAS_MULDIV` → MULDIV, with the counter loaded to `MULDIV_CYCLES-1`.
  - Anything else → EXEC.
- EXEC: Load/Store → MEM. Everything else → WB.
- MEM:
  - `mem_req=1`; `memRead=1` for Load; `memWrite=mem_we=1` for Store.
  - On `mem_ack`: Load → WB; Store → FETCH with `pc_we=1`.
- MULDIV: the counter decrements each cycle. When it reaches 0 (checked that cycle), go to WB.
- WB:
  - `RegWrite=1` for every class except Branch and Store.
  - `pc_we=1`; go to FETCH.
- HALT: absorbing until reset. All strobes are 0.
- Strobes (`mem_req`, `mem_we`, `memRead`, `memWrite`, `RegWrite`, `ir_we`, `pc_we`) are combinational from state plus registered decode. They are 0 in every state not listed above.

## Timing
- Reset values: state=FETCH; all strobes 0; registered decode outputs 0; `muldiv_busy`, `halted` and `illegal` all 0; counter 0.
- `mem_ack` may arrive in the same cycle `mem_req` rises. That gives zero wait states.
  - While waiting, `mem_req`, `mem_we`, `memRead` and `memWrite` stay stable.
  - `mem_ack` is ignored whenever `mem_req=0`.
- Latency with zero wait states, counted from FETCH entry to the next FETCH:
  - R, I, LUI, AUIPC, JAL, JALR, Branch: 4 cycles.
  - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).
  - Load: 5 cycles.
  - MUL/DIV: 3+`MULDIV_CYCLES`.
  - Each memory wait cycle adds 1.
- Exactly one `pc_we` pulse per retired instruction. Exactly one `ir_we` pulse per fetch.
- `rst_n=0` sampled at an edge:
  - The next state is FETCH and all outputs return to their reset values, even mid-MEM or mid-MULDIV.
  - A pending request is dropped. An `mem_ack` arriving later while in FETCH completes the new fetch.
- With `MULDIV_CYCLES=1`, MULDIV lasts exactly one cycle.
- The counter width is `$clog2(MULDIV_CYCLES+1)`.

## Test plan
- R-type ADD (opcode 01100, `funct7_0=0`), with `mem_ack` tied high:
  - States 0→1→2→4→0.
  - `RegWrite=1` only in cycle 4, with `ALUOp=10`.
  - One `pc_we`.
- Load with a 3-cycle `mem_ack` delay in MEM:
  - `mem_req` and `memRead` are held for 3 cycles.
  - WB shows `memtoReg=1` and `RegWrite=1`.
  - Total 8 cycles.
- MUL (01100, `funct7_0=1`), `MULDIV_CYCLES=4`:
  - `muldiv_busy` is high for exactly 4 cycles, then WB.
  - Total 7 cycles.
  - Same stimulus with `HAS_MULDIV=0` gives 4 cycles.
- Opcode 11100, then opcode 11111:
  - Each goes to HALT from DECODE.
  - `halted=1`, and `illegal=1` only for 11111.
  - No further `mem_req` until `rst_n=0`.
- Branch then Store:
  - Branch: `branch=1`, `RegWrite` never 1.
  - Store: `mem_we=memWrite=1` in MEM and `pc_we` on the ack cycle.
- Assert `rst_n=0` in the 2nd MULDIV cycle and during a stalled MEM:
  - The next cycle is FETCH with all strobes 0.
  - A stale `mem_ack` with `mem_req=0` causes no transition.
